// File: rtl/bsg_gateway_rail_seq.sv
// Power-rail enable sequencer: ramps rails up in ascending order and down in descending order,
// one step every step_delay_p cycles. Define BSG_GATEWAY_RAIL_OVERRIDE_EN for the CPU override.
module bsg_gateway_rail_seq #(
    parameter int unsigned num_rails_p   = 3,
    parameter int unsigned delay_width_p = 16,
    parameter int unsigned step_delay_p  = 1000
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   pwr_rstn_i,
    input  logic                   en_req_i,
    input  logic                   override_p_i,
    input  logic                   override_n_i,
    input  logic [num_rails_p-1:0] gpio_en_i,
    output logic [num_rails_p-1:0] rail_en_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   override_o
);

    typedef enum logic [2:0] {
        StIdleOff,
        StRampUp,
        StOn,
        StRampDown,
        StOverride
    } state_e;

    localparam logic [delay_width_p-1:0] StepReload = delay_width_p'(step_delay_p - 1);
    localparam logic [num_rails_p-1:0]   FirstRail  = num_rails_p'(1);

    state_e                   state_q, state_d;
    logic [num_rails_p-1:0]   rail_q, rail_d;
    logic [delay_width_p-1:0] cnt_q, cnt_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     override_q, override_d;

    logic                     guard;
    logic [num_rails_p-1:0]   gpio_sel;

`ifdef BSG_GATEWAY_RAIL_OVERRIDE_EN
    assign guard    = override_p_i & ~override_n_i;
    assign gpio_sel = gpio_en_i;
`else
    logic unused_override;
    assign unused_override = ^{override_p_i, override_n_i, gpio_en_i};
    assign guard    = 1'b0;
    assign gpio_sel = '0;
`endif

    // Clears the highest set bit; rails may be non-contiguous after an override.
    function automatic logic [num_rails_p-1:0] clear_highest(input logic [num_rails_p-1:0] v);
        logic [num_rails_p-1:0] r;
        r = v;
        for (int i = 0; i < int'(num_rails_p); i++) begin
            if (v[i] && ((v >> (i + 1)) == '0)) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        rail_d  = rail_q;
        cnt_d   = cnt_q;

        if (!pwr_rstn_i) begin
            state_d = StIdleOff;
            rail_d  = '0;
            cnt_d   = '0;
        end else if (guard) begin
            state_d = StOverride;
            rail_d  = gpio_sel;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdleOff: begin
                    if (en_req_i) begin
                        state_d = StRampUp;
                        rail_d  = FirstRail;
                        cnt_d   = StepReload;
                    end
                end
                StRampUp: begin
                    if (!en_req_i) begin
                        state_d = StRampDown;
                        rail_d  = clear_highest(rail_q);
                        cnt_d   = StepReload;
                    end else if (cnt_q == '0) begin
                        if (&rail_q) begin
                            state_d = StOn;
                        end else begin
                            // Sets the lowest clear bit, i.e. the next rail in order.
                            rail_d = rail_q | (rail_q + FirstRail);
                            cnt_d  = StepReload;
                        end
                    end else begin
                        cnt_d = cnt_q - delay_width_p'(1);
                    end
                end
                StOn: begin
                    if (!en_req_i) begin
                        state_d = StRampDown;
                        rail_d  = clear_highest(rail_q);
                        cnt_d   = StepReload;
                    end
                end
                StRampDown: begin
                    if (cnt_q == '0) begin
                        if (rail_q == '0) begin
                            state_d = StIdleOff;
                        end else begin
                            rail_d = clear_highest(rail_q);
                            cnt_d  = StepReload;
                        end
                    end else begin
                        cnt_d = cnt_q - delay_width_p'(1);
                    end
                end
                StOverride: begin
                    state_d = StRampDown;
                    rail_d  = clear_highest(rail_q);
                    cnt_d   = StepReload;
                end
                default: begin
                    state_d = StIdleOff;
                    rail_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d     = (state_d == StRampUp) || (state_d == StRampDown);
        done_d     = (state_d == StOn);
        override_d = (state_d == StOverride);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdleOff;
            rail_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            override_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rail_q     <= rail_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            override_q <= override_d;
        end
    end

    assign rail_en_o  = rail_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign override_o = override_q;

endmodule
